// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: ID/EX mult/div control bundle, operands, HI/LO access and status.
//   master: pipeline side (drives start/op/a/b/hilo_we/hilo_sel/wdata/rd_sel[/acc])
//   slave:  mult_div_unit (drives busy/rdata/hi/lo)
//   With MULT_DIV_ACC_EN defined, an extra acc input selects madd/maddu.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] wdata;
  logic        rd_sel;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULT_DIV_ACC_EN
  logic        acc;
  modport master (output start, op, a, b, hilo_we, hilo_sel, wdata, rd_sel, acc, input busy, rdata, hi, lo);
  modport slave  (input start, op, a, b, hilo_we, hilo_sel, wdata, rd_sel, acc, output busy, rdata, hi, lo);
`else
  modport master (output start, op, a, b, hilo_we, hilo_sel, wdata, rd_sel, input busy, rdata, hi, lo);
  modport slave  (input start, op, a, b, hilo_we, hilo_sel, wdata, rd_sel, output busy, rdata, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle mult/multu/div/divu unit with architectural HI/LO registers.
//   clk, rst (async active-high); bus: mult_div_unit_if.slave
//   start/op/a/b launch an op; hilo_we/hilo_sel/wdata do mthi/mtlo; rd_sel picks rdata;
//   busy flags an op in flight; hi/lo expose the registers.
//   Optional MULT_DIV_ACC_EN adds bus.acc for madd/maddu accumulation into {HI,LO}.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, lo_q, rhi, rlo;
  logic          dz_q, launch, done;
  logic          na, nb;
  logic [31:0]   ma, mb, q, r;
  logic [63:0]   prod, mres, res;
  // Division works on magnitudes and fixes signs afterwards, which also makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 instead of trapping.
  always_comb begin
    na = ~bus.op[0] & bus.a[31];
    nb = ~bus.op[0] & bus.b[31];
    prod = {{32{na}}, bus.a} * {{32{nb}}, bus.b};
`ifdef MULT_DIV_ACC_EN
    mres = bus.acc ? prod + {hi_q, lo_q} : prod;
`else
    mres = prod;
`endif
    ma = na ? -bus.a : bus.a;
    mb = nb ? -bus.b : bus.b;
    q = mb == '0 ? '0 : ma / mb;
    r = mb == '0 ? '0 : ma % mb;
    res = bus.op[1] ? {na ? -r : r, (na ^ nb) ? -q : q} : mres;
  end
  always_comb begin
    launch = state_q == IDLE && bus.start;
    done = state_q == RUN && cnt_q == CW'(1);
    state_d = launch ? RUN : done ? IDLE : state_q;
    cnt_d = launch ? (bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : state_q == RUN ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      rhi <= '0;
      rlo <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (launch) begin
        {rhi, rlo} <= res;
        dz_q <= bus.op[1] && bus.b == '0;
      end
      if (done && !dz_q) {hi_q, lo_q} <= {rhi, rlo};
      else if (state_q == IDLE && !bus.start && bus.hilo_we) begin
        if (bus.hilo_sel) hi_q <= bus.wdata;
        else lo_q <= bus.wdata;
      end
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.rdata = bus.rd_sel ? hi_q : lo_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed vectors.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int n;} exp_t;
  exp_t sb[$];
  mult_div_unit_if bus ();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int n);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    sb.push_back('{ehi, elo, n});
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
    cyc();
  endtask

  task automatic mt(input logic sel, input logic [31:0] d);
    bus.hilo_we = 1'b1;
    bus.hilo_sel = sel;
    bus.wdata = d;
    cyc();
    bus.hilo_we = 1'b0;
  endtask

  // Monitor: every busy fall outside reset is a completion; compare against the queue.
  logic prev_busy = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_busy <= 1'b0;
      run = 0;
    end else begin
      if (bus.busy) run++;
      if (prev_busy && !bus.busy) begin
        if (sb.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_hi", bus.hi, e.hi);
          chk("sb_lo", bus.lo, e.lo);
          chk("sb_busy_cycles", 32'(run), 32'(e.n));
        end
        run = 0;
      end
      prev_busy <= bus.busy;
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.hilo_we = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.wdata = '0;
    bus.rd_sel = 1'b0;
`ifdef MULT_DIV_ACC_EN
    bus.acc = 1'b0;
`endif
    repeat (2) cyc();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    rst = 1'b0;
    cyc();
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.a = 32'd3;
    bus.b = 32'd4;
    cyc();
    bus.start = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("midop_rst_busy", 32'(bus.busy), 32'd0);
    chk("midop_rst_hi", bus.hi, 32'd0);
    chk("midop_rst_lo", bus.lo, 32'd0);
    cyc();
    rst = 1'b0;
    repeat (7) cyc();
    chk("no_writeback_busy", 32'(bus.busy), 32'd0);
    chk("no_writeback_hi", bus.hi, 32'd0);
    chk("no_writeback_lo", bus.lo, 32'd0);
    issue(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    wait_idle();
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    wait_idle();
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    wait_idle();
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_idle();
    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    chk("mthi", bus.hi, 32'h11);
    chk("mtlo", bus.lo, 32'h22);
    issue(2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 10);
    wait_idle();
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b0;
    bus.wdata = 32'h55;
    issue(2'b00, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 5);
    bus.hilo_we = 1'b0;
    cyc();
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.a = 32'd9;
    bus.b = 32'd2;
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b1;
    bus.wdata = 32'h99;
    cyc();
    bus.start = 1'b0;
    bus.hilo_we = 1'b0;
    chk("hold_hi_during_run", bus.hi, 32'h11);
    wait_idle();
    bus.rd_sel = 1'b1;
    #1;
    chk("rdata_hi", bus.rdata, 32'hFFFFFFFF);
    bus.rd_sel = 1'b0;
    #1;
    chk("rdata_lo", bus.rdata, 32'hFFFFFFF9);
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b0;
    bus.wdata = 32'h77;
    #1;
    chk("no_bypass", bus.rdata, 32'hFFFFFFF9);
    cyc();
    bus.hilo_we = 1'b0;
    chk("mtlo_after_edge", bus.rdata, 32'h77);
    chk("mtlo_other_kept", bus.hi, 32'hFFFFFFFF);
`ifdef MULT_DIV_ACC_EN
    bus.acc = 1'b1;
    issue(2'b01, 32'd2, 32'd3, 32'hFFFFFFFF, 32'h0000007D, 5);
    bus.acc = 1'b0;
    wait_idle();
`endif
    cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
- Consumes the mult/div control bundle registered by the ID/EX pipeline register: start, op, HI/LO write enable/select, HI/LO read select.
- Produces the HI/LO read value for mfhi/mflo.
- Produces `busy`; hazard logic combines `busy` with `start` to stall IF/ID and bubble ID/EX.

Parameters:
- MULT_CYCLES, 5, cycles from the start edge until the mult/multu result is in HI/LO (>=1).
- DIV_CYCLES, 10, cycles from the start edge until the div/divu result is in HI/LO (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high; clears all state.
- start  in  1  MultDivStart from ID/EX; launch operation this cycle.
- op  in  2  MultDivOp: 00 mult, 01 multu, 10 div, 11 divu.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- hilo_we  in  1  HiLoWe: mthi/mtlo write.
- hilo_sel  in  1  HiLo: write target, 1 = HI, 0 = LO.
- wdata  in  32  mthi/mtlo data (rs, forwarded).
- rd_sel  in  1  mfhi_lo: read select, 1 = HI, 0 = LO.
- busy  out  1  operation in flight.
- rdata  out  32  combinational rd_sel ? HI : LO.
- hi  out  32  HI register, for debug/trace.
- lo  out  32  LO register, for debug/trace.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI = 0, LO = 0, busy = 0, counter = 0, state IDLE.
  - Any pending result is discarded.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1; counter counts down.
- IDLE with start = 1 at edge T:
  - Latch op and compute the result into internal result registers, 64 bits {rhi, rlo}.
  - Load counter with MULT_CYCLES (op[1] = 0) or DIV_CYCLES (op[1] = 1).
  - Go to RUN; busy = 1 from T to T+N.
- RUN, each edge:
  - counter decrements.
  - At the edge where counter == 1: HI <= rhi, LO <= rlo, go to IDLE, busy = 0.
  - Result is visible on rdata/hi/lo after edge T+N.
- HI/LO hold their old values throughout RUN. An mfhi issued during RUN is the hazard unit's job to stall; the unit never presents partial results.
- Arithmetic:
  - mult: signed 32x32 -> 64, {HI, LO} = product.
  - multu: unsigned 32x32 -> 64, {HI, LO} = product.
  - div: LO = quotient truncated toward zero; HI = remainder, sign of the dividend.
  - divu: unsigned LO = a / b, HI = a % b.
- Divide by zero (b == 0, div or divu):
  - Full DIV_CYCLES of busy.
  - HI/LO unchanged at completion.
  - No exception raised.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start while busy: ignored, no restart, no error.
- hilo_we in IDLE without start: at the edge, the selected register <= wdata; the other register is unchanged.
- hilo_we while busy: ignored.
- start and hilo_we in the same cycle: start wins, write dropped.
- rdata is purely combinational from HI/LO and rd_sel. No bypass of a same-cycle mthi/mtlo write.

Optional Feature:
- Macro: MULT_DIV_ACC_EN.
- With the macro:
  - Adds input port `acc` (1 bit).
  - When start = 1, acc = 1 and op is mult or multu: result = {HI, LO} + product, modulo 2^64 (madd/maddu).
  - The {HI, LO} addend is sampled at the start edge.
  - Latency is MULT_CYCLES.
  - acc is ignored for div/divu.
- Without the macro: no `acc` port; behaviour exactly as above.

Test Plan:
- Reset mid-op: start mult a = 3, b = 4, assert rst 2 cycles later -> busy = 0 and HI = LO = 0 immediately; no write-back after MULT_CYCLES.
- Signed mult: start mult a = 0xFFFFFFFE (-2), b = 3 -> busy high exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- multu: start multu a = 0xFFFFFFFF, b = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001 after 5 cycles.
- Signed div: start div a = -7, b = 2 -> busy 10 cycles; then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
- Div by zero: preload via mthi 0x11, mtlo 0x22; start divu b = 0 -> busy 10 cycles; HI = 0x11, LO = 0x22 unchanged.
- Collisions: start mult with hilo_we = 1 (hilo_sel = 0, wdata = 0x55) -> write dropped and mult result lands. Then second start during busy -> ignored; busy falls at the original T+5. Then rd_sel toggles -> rdata switches between HI and LO in the same cycle.
